// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the LCD text sequencer.
`timescale 1ns/1ps
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2    = 8'hC0;
    localparam logic [7:0] LCD_CHAR_SPACE   = 8'h20;

    localparam logic [5:0] CFG_LAST_STEP  = 6'd3;
    localparam logic [5:0] LINE2_STEP     = 6'd17;
    localparam logic [5:0] DRAW_LAST_STEP = 6'd33;

    typedef enum logic [1:0] {
        S_PWRUP,
        S_CFG,
        S_IDLE,
        S_DRAW
    } seq_state_t;

    typedef enum logic [1:0] {
        T_ISSUE,
        T_WAIT_DONE,
        T_XWAIT,
        T_GAP
    } tx_state_t;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_CMD_FUNC_SET;
            2'd1:    return LCD_CMD_ENTRY;
            2'd2:    return LCD_CMD_DISP_ON;
            default: return LCD_CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Nanosecond wait timer: start clears and arms it; expired pulses once when
// the accumulated time reaches target.
`timescale 1ns/1ps
module lcd_wait_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  period_clk_ns,
    input  logic        start,
    input  logic [24:0] target,
    output logic        expired
);

    logic [24:0] r_count;
    logic        r_active;
    logic        r_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_active  <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (start) begin
                r_count  <= '0;
                r_active <= 1'b1;
            end else if (r_active) begin
                if (r_count >= target) begin
                    r_expired <= 1'b1;
                    r_active  <= 1'b0;
                    r_count   <= '0;
                end else begin
                    r_count <= r_count + 25'(period_clk_ns);
                end
            end
        end
    end

    assign expired = r_expired;

endmodule

// File: rtl/lcd_text_sequencer.sv
// Feeds configuration and 2x16 text bytes to the 4-bit LCD controller over
// its rs/data/strobe/done handshake, adding power-up and clear settle waits.
`timescale 1ns/1ps
module lcd_text_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned STARTUP_WAIT_NS = 20_000_000,
    parameter int unsigned CLEAR_WAIT_NS   = 1_640_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] period_clk_ns,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    input  logic       lcd_done,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       lcd_strobe,
    output logic       busy,
    output logic       ready
);

    localparam logic [24:0] STARTUP_TARGET = 25'(STARTUP_WAIT_NS);
    localparam logic [24:0] CLEAR_TARGET   = 25'(CLEAR_WAIT_NS);

    seq_state_t  r_state, w_state_nx;
    tx_state_t   r_tx, w_tx_nx;
    logic [5:0]  r_step, w_step_nx;
    logic        r_rs, w_rs_nx;
    logic [7:0]  r_data, w_data_nx;
    logic        r_strobe, w_strobe_nx;
    logic        r_ready, w_ready_nx;
    logic        r_pending, w_pending_nx;
    logic        r_pwrup_go;
    logic [7:0]  r_buf [32];

    logic        w_tmr_start;
    logic        w_tmr_expired;
    logic [24:0] w_tmr_target;
    logic [4:0]  w_char_addr;
    logic        w_byte_rs;
    logic [7:0]  w_byte_data;
    logic        w_last_step;

    lcd_wait_timer u_timer (
        .clk           (clk),
        .rst           (rst),
        .period_clk_ns (period_clk_ns),
        .start         (w_tmr_start),
        .target        (w_tmr_target),
        .expired       (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) r_buf[i] <= LCD_CHAR_SPACE;
        end else if (wr_en) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Step 0 and step 17 are the line address commands; the rest map to buffer slots.
    assign w_char_addr  = (r_step < LINE2_STEP) ? 5'(r_step - 6'd1) : 5'(r_step - 6'd2);
    assign w_tmr_target = (r_state == S_PWRUP) ? STARTUP_TARGET : CLEAR_TARGET;
    assign w_last_step  = (r_state == S_CFG) ? (r_step == CFG_LAST_STEP)
                                             : (r_step == DRAW_LAST_STEP);

    always_comb begin
        w_byte_rs   = 1'b1;
        w_byte_data = r_buf[w_char_addr];
        if (r_state == S_CFG) begin
            w_byte_rs   = 1'b0;
            w_byte_data = cfg_byte(r_step[1:0]);
        end else if (r_step == 6'd0) begin
            w_byte_rs   = 1'b0;
            w_byte_data = LCD_CMD_LINE1;
        end else if (r_step == LINE2_STEP) begin
            w_byte_rs   = 1'b0;
            w_byte_data = LCD_CMD_LINE2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_PWRUP;
            r_tx       <= T_ISSUE;
            r_step     <= '0;
            r_rs       <= 1'b0;
            r_data     <= '0;
            r_strobe   <= 1'b0;
            r_ready    <= 1'b0;
            r_pending  <= 1'b0;
            r_pwrup_go <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_tx       <= w_tx_nx;
            r_step     <= w_step_nx;
            r_rs       <= w_rs_nx;
            r_data     <= w_data_nx;
            r_strobe   <= w_strobe_nx;
            r_ready    <= w_ready_nx;
            r_pending  <= w_pending_nx;
            r_pwrup_go <= 1'b0;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_tx_nx      = r_tx;
        w_step_nx    = r_step;
        w_rs_nx      = r_rs;
        w_data_nx    = r_data;
        w_strobe_nx  = 1'b0;
        w_ready_nx   = r_ready;
        w_pending_nx = r_pending | refresh;
        w_tmr_start  = r_pwrup_go;

        case (r_state)
            S_PWRUP: begin
                if (w_tmr_expired) begin
                    w_state_nx = S_CFG;
                    w_tx_nx    = T_ISSUE;
                    w_step_nx  = '0;
                end
            end
            S_IDLE: begin
                if (refresh || r_pending) begin
                    w_state_nx   = S_DRAW;
                    w_tx_nx      = T_ISSUE;
                    w_step_nx    = '0;
                    w_pending_nx = 1'b0;
                end
            end
            S_CFG, S_DRAW: begin
                case (r_tx)
                    T_ISSUE: begin
                        w_rs_nx     = w_byte_rs;
                        w_data_nx   = w_byte_data;
                        w_strobe_nx = 1'b1;
                        w_tx_nx     = T_WAIT_DONE;
                    end
                    T_WAIT_DONE: begin
                        if (lcd_done) begin
                            if (!r_rs && r_data == LCD_CMD_CLEAR) begin
                                w_tx_nx     = T_XWAIT;
                                w_tmr_start = 1'b1;
                            end else begin
                                w_tx_nx = T_GAP;
                            end
                        end
                    end
                    T_XWAIT: begin
                        if (w_tmr_expired) w_tx_nx = T_GAP;
                    end
                    default: begin
                        w_tx_nx   = T_ISSUE;
                        w_step_nx = r_step + 6'd1;
                        if (w_last_step) begin
                            w_step_nx = '0;
                            // A request queued during power-up/config chains straight into a draw.
                            if (r_state == S_CFG) begin
                                w_ready_nx = 1'b1;
                                if (r_pending || refresh) begin
                                    w_state_nx   = S_DRAW;
                                    w_pending_nx = 1'b0;
                                end else begin
                                    w_state_nx = S_IDLE;
                                end
                            end else begin
                                w_state_nx = S_IDLE;
                            end
                        end
                    end
                endcase
            end
            default: w_state_nx = S_PWRUP;
        endcase
    end

    assign lcd_rs     = r_rs;
    assign lcd_data   = r_data;
    assign lcd_strobe = r_strobe;
    assign busy       = (r_state != S_IDLE);
    assign ready      = r_ready;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Randomized self-checking bench: behavioural LCD controller plus a
// buffer/pass-level model of the expected byte stream and timing.
`timescale 1ns/1ps
module tb_lcd_text_sequencer;

    localparam int STARTUP_NS = 20_000;
    localparam int CLEAR_NS   = 1_640;
    localparam int PER        = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] period_clk_ns = 8'(PER);
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       refresh = 1'b0;
    logic       lcd_done = 1'b0;
    logic       lcd_rs;
    logic [7:0] lcd_data;
    logic       lcd_strobe;
    logic       busy;
    logic       ready;

    lcd_text_sequencer #(
        .STARTUP_WAIT_NS (STARTUP_NS),
        .CLEAR_WAIT_NS   (CLEAR_NS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .period_clk_ns (period_clk_ns),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .refresh       (refresh),
        .lcd_done      (lcd_done),
        .lcd_rs        (lcd_rs),
        .lcd_data      (lcd_data),
        .lcd_strobe    (lcd_strobe),
        .busy          (busy),
        .ready         (ready)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state
    logic [7:0] mdl_buf [32];
    logic [7:0] cfg_tbl [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};
    int  mdl_cfg_n, mdl_pos, mdl_passes = 0;
    bit  mdl_want;
    int  cyc = 0, rel_cyc = 0, last_done_cyc, clr_done_cyc;
    bit  in_flight, just_rose, hold_bad, saw_idle, t6_mode = 1'b0;
    bit  prev_strobe = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
    logic       cap_rs;
    logic [7:0] cap_data;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl_buf[i] = 8'h20;
        mdl_cfg_n     = 0;
        mdl_pos       = 0;
        mdl_want      = 1'b0;
        in_flight     = 1'b0;
        just_rose     = 1'b0;
        saw_idle      = 1'b0;
        last_done_cyc = -1000;
        clr_done_cyc  = 0;
    endtask

    initial forever #10 clk = ~clk;

    initial begin
        #4_000_000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    // Controller: done pulse a few cycles after each strobe, abandoned by rst.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                cnt = 0;
                lcd_done = 1'b0;
            end else begin
                lcd_done = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) lcd_done = 1'b1;
                end
                if (lcd_strobe) cnt = $urandom_range(4, 12);
            end
        end
    end

    // Monitor and reference model, sampled on the falling edge.
    initial begin
        logic       exp_rs;
        logic [7:0] exp_d;
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                model_reset();
                prev_rst = 1'b1;
            end else begin
                if (prev_rst) rel_cyc = cyc - 1;
                prev_rst = 1'b0;
                if (!busy) saw_idle = 1'b1;
                if (just_rose) begin
                    chk("strobe_width", lcd_strobe, 0);
                    just_rose = 1'b0;
                end
                if (lcd_strobe && !prev_strobe) begin
                    chk("overlap", in_flight, 0);
                    chk("gap_after_done", (cyc - last_done_cyc) >= 2, 1);
                    if (mdl_cfg_n < 4) begin
                        if (mdl_cfg_n == 0)
                            chk("pwrup_wait", (cyc - rel_cyc) * PER >= STARTUP_NS, 1);
                        exp_rs = 1'b0;
                        exp_d  = cfg_tbl[mdl_cfg_n];
                        mdl_cfg_n++;
                    end else begin
                        if (mdl_pos == 0) begin
                            chk("pass_requested", mdl_want, 1);
                            mdl_want = 1'b0;
                            if (t6_mode) begin
                                chk("no_idle_gap", saw_idle, 0);
                                t6_mode = 1'b0;
                            end
                        end
                        if (mdl_pos == 0) begin
                            exp_rs = 1'b0; exp_d = 8'h80;
                        end else if (mdl_pos == 17) begin
                            exp_rs = 1'b0; exp_d = 8'hC0;
                        end else if (mdl_pos < 17) begin
                            exp_rs = 1'b1; exp_d = mdl_buf[mdl_pos - 1];
                        end else begin
                            exp_rs = 1'b1; exp_d = mdl_buf[mdl_pos - 2];
                        end
                        mdl_pos++;
                        if (mdl_pos == 34) begin
                            mdl_pos = 0;
                            mdl_passes++;
                        end
                    end
                    chk("byte_rs", lcd_rs, exp_rs);
                    chk("byte_data", lcd_data, exp_d);
                    cap_rs    = lcd_rs;
                    cap_data  = lcd_data;
                    in_flight = 1'b1;
                    hold_bad  = 1'b0;
                    just_rose = 1'b1;
                end else if (in_flight) begin
                    if (lcd_rs !== cap_rs || lcd_data !== cap_data) hold_bad = 1'b1;
                    if (lcd_done) begin
                        chk("hold_until_done", hold_bad, 0);
                        in_flight     = 1'b0;
                        last_done_cyc = cyc;
                        if (!cap_rs && cap_data == 8'h01) clr_done_cyc = cyc;
                    end
                end
                if (ready && !prev_ready) begin
                    chk("ready_after_cfg", (mdl_cfg_n == 4) && !in_flight, 1);
                    chk("clear_wait", (cyc - clr_done_cyc) * PER >= CLEAR_NS, 1);
                end
                if (wr_en) mdl_buf[wr_addr] = wr_data;
                if (refresh) mdl_want = 1'b1;
            end
            prev_strobe = lcd_strobe;
            prev_ready  = ready;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (!(busy === 1'b0 && !mdl_want && mdl_pos == 0 && mdl_cfg_n == 4 && !in_flight)
               && n < max_cyc) begin
            tick();
            n++;
        end
        chk("idle_reached", n < max_cyc, 1);
        chk("ready_high", ready, 1);
    endtask

    task automatic wait_pos(input int p, input int max_cyc);
        int n;
        n = 0;
        while (mdl_pos != p && n < max_cyc) begin
            tick();
            n++;
        end
        chk("pos_reached", n < max_cyc, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rs"},     lcd_rs, 0);
        chk({tag, "_data"},   lcd_data, 8'h00);
        chk({tag, "_strobe"}, lcd_strobe, 0);
        chk({tag, "_busy"},   busy, 1);
        chk({tag, "_ready"},  ready, 0);
    endtask

    initial begin
        int p0;
        repeat (3) tick();
        check_reset_outputs("rst0");
        rst = 1'b0;

        // Power-up and configuration
        wait_idle(3000);

        // Directed draw
        host_write(5'h00, 8'h48);
        host_write(5'h11, 8'h69);
        p0 = mdl_passes;
        pulse_refresh();
        wait_idle(2000);
        chk("t2_passes", mdl_passes - p0, 1);

        // Random writes and refreshes in any state
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 400; k++) begin
                wr_en   = 1'($urandom_range(0, 1));
                wr_addr = 5'($urandom_range(0, 31));
                wr_data = 8'($urandom_range(0, 255));
                refresh = ($urandom_range(0, 39) == 0);
                tick();
            end
            wr_en = 1'b0;
            refresh = 1'b0;
            wait_idle(6000);
        end

        // Multiple requests during a pass collapse into one more pass
        p0 = mdl_passes;
        pulse_refresh();
        wait_pos(5, 1000);
        pulse_refresh();
        repeat (7) tick();
        pulse_refresh();
        wait_pos(20, 1000);
        pulse_refresh();
        wait_idle(3000);
        chk("t4_passes", mdl_passes - p0, 2);

        // Reset in the middle of a draw
        host_write(5'h03, 8'h41);
        host_write(5'h1F, 8'h5A);
        pulse_refresh();
        wait_pos(10, 1000);
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        wait_idle(3000);
        p0 = mdl_passes;
        pulse_refresh();
        wait_idle(2000);
        chk("t5_passes", mdl_passes - p0, 1);

        // Refresh during power-up runs straight into a draw after config
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (100) tick();
        t6_mode = 1'b1;
        pulse_refresh();
        wait_idle(3000);
        chk("t6_draw_seen", t6_mode, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
